// File: rtl/dualshock_poller.sv
// Purpose : polls a DualShock pad (0x01 0x42 0x00 0x00 0x00) and publishes the active-low button word.
// Latency : outputs update one cycle after the frame's DONE cycle; frames repeat POLL_INTERVAL cycles after DONE.
// Backpress: none; the pad link is master-driven and consumers just sample pad_buttons/pad_id on frame_valid.
// Ports   : clk/reset (sync, active-high); pad_dat/pad_ack async pad inputs (2-FF synchronized);
//           pad_att/pad_clk/pad_cmd pad link outputs; pad_buttons/pad_id last good frame data;
//           frame_valid one-cycle update strobe; link_error sticky until the next good frame.
module dualshock_poller #(
  parameter int CLK_DIV       = 100,
  parameter int POLL_INTERVAL = 833_333,
  parameter int ACK_TIMEOUT   = 5000,
  parameter int BYTE_GAP      = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pad_dat,
  input  logic        pad_ack,
  output logic        pad_att,
  output logic        pad_clk,
  output logic        pad_cmd,
  output logic [15:0] pad_buttons,
  output logic [7:0]  pad_id,
  output logic        frame_valid,
  output logic        link_error
);

  localparam int MAX_A   = (CLK_DIV > BYTE_GAP) ? CLK_DIV : BYTE_GAP;
  localparam int MAX_B   = (POLL_INTERVAL > ACK_TIMEOUT) ? POLL_INTERVAL : ACK_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] IDLE_LAST = CW'(POLL_INTERVAL - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ATT_SETUP, SHIFT, ACK_WAIT, GAP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic          phase_q, phase_d;       // 0 = pad_clk low half, 1 = high half
  logic          abort_q, abort_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx1_q, rx1_d, rx2_q, rx2_d, rx3_q, rx3_d, rx4_q, rx4_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          ack_meta_q, ack_meta_d, ack_sync_q, ack_sync_d;
  logic          pad_att_q, pad_att_d, pad_clk_q, pad_clk_d, pad_cmd_q, pad_cmd_d;
  logic [15:0]   buttons_q, buttons_d;
  logic [7:0]    id_q, id_d;
  logic          frame_valid_q, frame_valid_d, link_error_q, link_error_d;

  // Poll command: byte 0 = 0x01, byte 1 = 0x42, remaining bytes 0x00.
  function automatic logic cmd_bit(input logic [2:0] byte_sel, input logic [2:0] bit_sel);
    logic [7:0] cmd_byte;
    case (byte_sel)
      3'd0:    cmd_byte = 8'h01;
      3'd1:    cmd_byte = 8'h42;
      default: cmd_byte = 8'h00;
    endcase
    return cmd_byte[bit_sel];
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(1);
    bit_idx_d     = bit_idx_q;
    byte_idx_d    = byte_idx_q;
    phase_d       = phase_q;
    abort_d       = abort_q;
    rx_sh_d       = rx_sh_q;
    rx1_d         = rx1_q;
    rx2_d         = rx2_q;
    rx3_d         = rx3_q;
    rx4_d         = rx4_q;
    buttons_d     = buttons_q;
    id_d          = id_q;
    frame_valid_d = 1'b0;
    link_error_d  = link_error_q;
    dat_meta_d    = pad_dat;
    dat_sync_d    = dat_meta_q;
    ack_meta_d    = pad_ack;
    ack_sync_d    = ack_meta_q;

    case (state_q)
      IDLE: begin
        if (cnt_q == IDLE_LAST) begin
          state_d = ATT_SETUP;
          cnt_d   = '0;
        end
      end
      ATT_SETUP: begin
        if (cnt_q == GAP_LAST) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          phase_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Last cycle of the high half: the pad has had the whole bit time to settle DAT.
            rx_sh_d[bit_idx_q] = dat_sync_q;
            phase_d            = 1'b0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_d = 3'd0;
              case (byte_idx_q)
                3'd1:    rx1_d = rx_sh_d;
                3'd2:    rx2_d = rx_sh_d;
                3'd3:    rx3_d = rx_sh_d;
                3'd4:    rx4_d = rx_sh_d;
                default: ;
              endcase
              state_d = (byte_idx_q == 3'd4) ? DONE : ACK_WAIT;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end
      ACK_WAIT: begin
        // ACK wins over a timeout that expires in the same cycle.
        if (!ack_sync_q) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == ACK_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          abort_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d    = SHIFT;
          cnt_d      = '0;
          byte_idx_d = byte_idx_q + 3'd1;
          bit_idx_d  = 3'd0;
          phase_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        abort_d = 1'b0;
        if (!abort_q && (rx1_q == 8'h41 || rx1_q == 8'h73) && rx2_q == 8'h5A) begin
          buttons_d     = {rx4_q, rx3_q};
          id_d          = rx1_q;
          frame_valid_d = 1'b1;
          link_error_d  = 1'b0;
        end else begin
          link_error_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pad pins are registered from the next-state view so they line up with state_q.
    pad_att_d = (state_d == IDLE) || (state_d == DONE);
    pad_clk_d = !((state_d == SHIFT) && !phase_d);
    pad_cmd_d = (state_d == SHIFT) ? cmd_bit(byte_idx_d, bit_idx_d) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      byte_idx_q    <= 3'd0;
      phase_q       <= 1'b0;
      abort_q       <= 1'b0;
      rx_sh_q       <= 8'h00;
      rx1_q         <= 8'h00;
      rx2_q         <= 8'h00;
      rx3_q         <= 8'h00;
      rx4_q         <= 8'h00;
      dat_meta_q    <= 1'b1;
      dat_sync_q    <= 1'b1;
      ack_meta_q    <= 1'b1;
      ack_sync_q    <= 1'b1;
      pad_att_q     <= 1'b1;
      pad_clk_q     <= 1'b1;
      pad_cmd_q     <= 1'b1;
      buttons_q     <= 16'hFFFF;
      id_q          <= 8'h00;
      frame_valid_q <= 1'b0;
      link_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      byte_idx_q    <= byte_idx_d;
      phase_q       <= phase_d;
      abort_q       <= abort_d;
      rx_sh_q       <= rx_sh_d;
      rx1_q         <= rx1_d;
      rx2_q         <= rx2_d;
      rx3_q         <= rx3_d;
      rx4_q         <= rx4_d;
      dat_meta_q    <= dat_meta_d;
      dat_sync_q    <= dat_sync_d;
      ack_meta_q    <= ack_meta_d;
      ack_sync_q    <= ack_sync_d;
      pad_att_q     <= pad_att_d;
      pad_clk_q     <= pad_clk_d;
      pad_cmd_q     <= pad_cmd_d;
      buttons_q     <= buttons_d;
      id_q          <= id_d;
      frame_valid_q <= frame_valid_d;
      link_error_q  <= link_error_d;
    end
  end

  assign pad_att     = pad_att_q;
  assign pad_clk     = pad_clk_q;
  assign pad_cmd     = pad_cmd_q;
  assign pad_buttons = buttons_q;
  assign pad_id      = id_q;
  assign frame_valid = frame_valid_q;
  assign link_error  = link_error_q;

endmodule

// File: tb/tb_dualshock_poller.sv
// Bench for dualshock_poller: behavioural pad on the link, scoreboard of per-frame outcomes,
// monitor that checks outputs, frame_valid width, poll cadence and ACK-timeout abort timing.
module tb_dualshock_poller;

  localparam int CD = 4;
  localparam int PI = 20;
  localparam int AT = 16;
  localparam int BG = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pad_dat = 1'b1;
  logic        pad_ack = 1'b1;
  logic        pad_att, pad_clk, pad_cmd;
  logic [15:0] pad_buttons;
  logic [7:0]  pad_id;
  logic        frame_valid, link_error;

  dualshock_poller #(.CLK_DIV(CD), .POLL_INTERVAL(PI), .ACK_TIMEOUT(AT), .BYTE_GAP(BG)) dut (
    .clk(clk), .reset(reset), .pad_dat(pad_dat), .pad_ack(pad_ack),
    .pad_att(pad_att), .pad_clk(pad_clk), .pad_cmd(pad_cmd),
    .pad_buttons(pad_buttons), .pad_id(pad_id),
    .frame_valid(frame_valid), .link_error(link_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fv;
    logic [15:0] btn;
    logic [7:0]  id;
    bit          lerr;
    bit          abort;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Pad configuration for the current frame, owned by the stimulus process.
  logic [7:0]  tx [5];
  logic [4:0]  ack_mask = 5'h0F;
  int          ack_dly = CD + 3;
  bit          glitch = 1'b0;
  // Pad progress, owned by the pad model.
  int          pad_byte = 0;
  int          pad_bit = 0;
  int          last_rise_cyc = 0;

  // Reference model state: what the outputs should hold after the last completed frame.
  logic [15:0] m_btn = 16'hFFFF;
  logic [7:0]  m_id = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural pad: drives DAT after each falling pad_clk, captures CMD on each rising edge,
  // and pulls ACK low for 4 cycles some delay after each acknowledged byte.
  initial begin : pad_model
    logic       pclk;
    int         ack_cnt;
    int         ack_lo;
    logic [7:0] cmd_sh;
    logic [7:0] exp_cmd [5];
    exp_cmd = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    pclk = 1'b1; ack_cnt = 0; ack_lo = 0; cmd_sh = 8'h00;
    forever begin
      @(negedge clk);
      if (pad_att) begin
        pad_byte = 0; pad_bit = 0; ack_cnt = 0; ack_lo = 0; pad_dat = 1'b1;
      end else if (pad_byte < 5) begin
        if (pclk && !pad_clk) pad_dat = tx[pad_byte][pad_bit];
        if (!pclk && pad_clk) begin
          cmd_sh[pad_bit] = pad_cmd;
          last_rise_cyc = cyc;
          if (glitch && pad_byte == 0 && pad_bit == 3) ack_lo = 4;
          if (pad_bit == 7) begin
            chk($sformatf("cmd_byte%0d", pad_byte), 32'(cmd_sh), 32'(exp_cmd[pad_byte]));
            if (ack_mask[pad_byte]) ack_cnt = ack_dly;
            pad_byte++;
            pad_bit = 0;
          end else begin
            pad_bit++;
          end
        end
      end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) ack_lo = 4;
      end
      pad_ack = (ack_lo == 0);
      if (ack_lo > 0) ack_lo--;
      pclk = pad_clk;
    end
  end

  // Monitor: a pad_att rise marks a DONE cycle; the next cycle carries the frame result.
  initial begin : monitor
    logic prev_att;
    int   fall_exp;
    int   chk_at;
    exp_t e;
    prev_att = 1'b1; fall_exp = -1; chk_at = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_att = 1'b1;
        chk_at   = -1;
        fall_exp = cyc + PI + 1;
        continue;
      end
      if (prev_att && !pad_att && fall_exp >= 0)
        chk("att_fall_cycle", 32'(cyc), 32'(fall_exp));
      if (!prev_att && pad_att) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame_end", 32'(1), 32'(0));
        end else begin
          e      = sb.pop_front();
          chk_at = cyc + 1;
          if (e.abort)
            chk("abort_att_rise", 32'(cyc), 32'(last_rise_cyc + CD + AT));
        end
        fall_exp = cyc + PI + 1;
      end
      if (cyc == chk_at) begin
        chk("frame_valid", 32'(frame_valid), 32'(e.fv));
        chk("pad_buttons", 32'(pad_buttons), 32'(e.btn));
        chk("pad_id", 32'(pad_id), 32'(e.id));
        chk("link_error", 32'(link_error), 32'(e.lerr));
        chk_at = -1;
      end else begin
        chk("frame_valid_idle", 32'(frame_valid), 32'(0));
      end
      prev_att = pad_att;
    end
  end

  task automatic wait_att(input logic lvl, input int bound, input string what);
    int n;
    n = 0;
    while (pad_att !== lvl && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (pad_att !== lvl) begin
      checks++; errors++;
      $display("FAIL %s: timeout, pad_att=%0b required %0b", what, pad_att, lvl);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_att"}, 32'(pad_att), 32'(1));
    chk({tag, "_clk"}, 32'(pad_clk), 32'(1));
    chk({tag, "_cmd"}, 32'(pad_cmd), 32'(1));
    chk({tag, "_buttons"}, 32'(pad_buttons), 32'hFFFF);
    chk({tag, "_id"}, 32'(pad_id), 32'(0));
    chk({tag, "_fv"}, 32'(frame_valid), 32'(0));
    chk({tag, "_lerr"}, 32'(link_error), 32'(0));
  endtask

  // Issue one frame: configure the pad, push the predicted outcome, optionally reset mid byte 3.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [4:0] mask,
                           input int dly, input bit gl, input bit mid_reset);
    exp_t e;
    bit   good;
    int   n;
    tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3; tx[4] = b4;
    ack_mask = mask; ack_dly = dly; glitch = gl;
    good    = (mask[3:0] == 4'hF) && (b1 == 8'h41 || b1 == 8'h73) && (b2 == 8'h5A);
    e.abort = (mask[3:0] != 4'hF);
    e.fv    = good;
    e.lerr  = !good;
    if (good) begin
      m_btn = {b4, b3};
      m_id  = b1;
    end
    e.btn = m_btn;
    e.id  = m_id;
    sb.push_back(e);
    if (mid_reset) begin
      n = 0;
      while (!(pad_byte == 3 && pad_bit == 2) && n < 2000) begin
        @(posedge clk); #1;
        n++;
      end
      if (!(pad_byte == 3 && pad_bit == 2)) begin
        checks++; errors++;
        $display("FAIL mid_reset_wait: timeout, pad_byte=%0d required 3", pad_byte);
      end
      void'(sb.pop_back());
      m_btn = 16'hFFFF;
      m_id  = 8'h00;
      reset = 1'b1;
      @(posedge clk); #1;
      reset_checks("midreset");
      @(posedge clk); #1;
      reset = 1'b0;
    end else begin
      wait_att(1'b0, PI + BG + 10, "frame_start");
      wait_att(1'b1, 2000, "frame_end");
      repeat (3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin : stimulus
    logic [7:0] hdr;
    logic [7:0] b2;
    logic [4:0] mask;
    tx = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // ACK timeout on byte 1: buttons stay released, link_error set.
    run_frame(8'hFF, 8'h41, 8'h5A, 8'hEF, 8'hBF, 5'b01101, CD + 3, 1'b0, 1'b0);
    // Good frame.
    run_frame(8'hFF, 8'h41, 8'h5A, 8'hEF, 8'hBF, 5'h0F, CD + 3, 1'b0, 1'b0);
    // Bad header byte 2: outputs hold, link_error set.
    run_frame(8'hFF, 8'h41, 8'h00, 8'h12, 8'h34, 5'h0F, CD + 3, 1'b0, 1'b0);
    // Good frame with 0x73 ID clears link_error.
    run_frame(8'hFF, 8'h73, 8'h5A, 8'h5C, 8'hA3, 5'h0F, CD + 3, 1'b0, 1'b0);
    // ACK already low when ACK_WAIT is entered.
    run_frame(8'hFF, 8'h41, 8'h5A, 8'h0F, 8'hF0, 5'h0F, 1, 1'b0, 1'b0);
    // ACK glitch during byte 0 shift must not disturb the frame.
    run_frame(8'hFF, 8'h41, 8'h5A, 8'h66, 8'h99, 5'h0F, CD + 3, 1'b1, 1'b0);
    // Reset in the middle of byte 3.
    run_frame(8'hFF, 8'h41, 8'h5A, 8'h11, 8'h22, 5'h0F, CD + 3, 1'b0, 1'b1);
    // Back-to-back good frames for cadence and pulse width.
    for (int i = 0; i < 3; i++)
      run_frame(8'hFF, 8'h73, 8'h5A, 8'($urandom), 8'($urandom), 5'h0F, CD + 3, 1'b0, 1'b0);
    // Randomized frames.
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 2))
        0:       hdr = 8'h41;
        1:       hdr = 8'h73;
        default: hdr = 8'($urandom);
      endcase
      b2   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h5A;
      mask = ($urandom_range(0, 3) == 0) ? (5'h0F & ~(5'd1 << $urandom_range(0, 3))) : 5'h0F;
      run_frame(8'($urandom), hdr, b2, 8'($urandom), 8'($urandom), mask,
                int'($urandom_range(1, CD + 8)), 1'($urandom_range(0, 1)), 1'b0);
    end

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d frames left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
